// File: rtl/led_pwm_pkg.sv
// Shared register map and bit positions for the led_pwm_ctrl PWM LED driver.
package led_pwm_pkg;

  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_PRESC  = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_DUTY0  = 5'd8;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_INVERT_BIT = 1;

  localparam int STATUS_WRAP_BIT = 8;

endpackage

// File: rtl/led_pwm_ctrl_channel.sv
// One PWM channel: pending/active duty double buffer, phase compare and a
// registered, optionally inverted LED output.
module pwm_channel #(
  parameter int DUTY_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [DUTY_W-1:0] i_wdata,
  input  logic [DUTY_W-1:0] i_phase,
  input  logic              i_load,
  input  logic              i_enable,
  input  logic              i_mask,
  input  logic              i_invert,
  output logic [DUTY_W-1:0] o_pending,
  output logic              o_led
);

  logic [DUTY_W-1:0] r_pending;
  logic [DUTY_W-1:0] r_active;
  logic              r_led;
  logic              w_raw;

  assign w_raw = i_enable & i_mask & (i_phase < r_active);

  // Active loads the pre-edge pending value, so a write landing on a wrap
  // edge only takes effect at the following wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_active  <= '0;
      r_led     <= 1'b0;
    end else begin
      if (i_wr_en) r_pending <= i_wdata;
      if (i_load)  r_active  <= r_pending;
      r_led <= w_raw ^ i_invert;
    end
  end

  assign o_pending = r_pending;
  assign o_led     = r_led;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped NCH-channel PWM LED driver: bus decode, prescaler, phase
// counter and sticky wrap status, driving one pwm_channel per LED.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bus_valid,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [31:0]       i_bus_wdata,
  output logic              o_bus_ready,
  output logic [31:0]       o_bus_rdata,
  output logic [NCH-1:0]    o_led
);

  logic                         r_bus_ready;
  logic [31:0]                  r_bus_rdata;
  logic                         r_req_we;
  logic [ADDR_W-1:0]            r_req_addr;
  logic [31:0]                  r_req_wdata;

  logic                         r_enable;
  logic                         r_invert;
  logic [NCH-1:0]               r_mask;
  logic [PRESC_W-1:0]           r_presc;
  logic [PRESC_W-1:0]           r_presc_cnt;
  logic [DUTY_W-1:0]            r_phase;
  logic                         r_wrap_flag;

  logic                         w_accept;
  logic                         w_wr;
  logic                         w_wr_ctrl;
  logic                         w_wr_mask;
  logic                         w_wr_presc;
  logic                         w_status_rd;
  logic                         w_tick;
  logic                         w_wrap;
  logic                         w_load;
  logic [31:0]                  w_rdata;
  logic [NCH-1:0]               w_duty_wr;
  logic [NCH-1:0][DUTY_W-1:0]   w_pending;
  logic                         w_unused_wdata;

  assign w_accept    = i_bus_valid & ~r_bus_ready;
  assign w_wr        = r_bus_ready & r_req_we;
  assign w_wr_ctrl   = w_wr && (r_req_addr == ADDR_CTRL);
  assign w_wr_mask   = w_wr && (r_req_addr == ADDR_MASK);
  assign w_wr_presc  = w_wr && (r_req_addr == ADDR_PRESC);
  assign w_status_rd = r_bus_ready && !r_req_we && (r_req_addr == ADDR_STATUS);
  assign w_unused_wdata = &{1'b0, r_req_wdata[31:PRESC_W]};

  // Writes commit at the end of the ready cycle, so new values appear two
  // cycles after acceptance; read data is captured at acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bus_ready <= 1'b0;
      r_bus_rdata <= '0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else begin
      r_bus_ready <= w_accept;
      r_bus_rdata <= (w_accept && !i_bus_we) ? w_rdata : '0;
      if (w_accept) begin
        r_req_we    <= i_bus_we;
        r_req_addr  <= i_bus_addr;
        r_req_wdata <= i_bus_wdata;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (i_bus_addr)
      ADDR_CTRL: begin
        w_rdata[CTRL_ENABLE_BIT] = r_enable;
        w_rdata[CTRL_INVERT_BIT] = r_invert;
      end
      ADDR_MASK:  w_rdata[NCH-1:0] = r_mask;
      ADDR_PRESC: w_rdata[PRESC_W-1:0] = r_presc;
      ADDR_STATUS: begin
        w_rdata[DUTY_W-1:0]      = r_phase;
        w_rdata[STATUS_WRAP_BIT] = r_wrap_flag;
      end
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (i_bus_addr == ADDR_DUTY0 + ADDR_W'(i)) w_rdata[DUTY_W-1:0] = w_pending[i];
        end
      end
    endcase
  end

  always_comb begin
    w_duty_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      w_duty_wr[i] = w_wr && (r_req_addr == ADDR_DUTY0 + ADDR_W'(i));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_enable <= 1'b0;
      r_invert <= 1'b0;
      r_mask   <= '0;
      r_presc  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= r_req_wdata[CTRL_ENABLE_BIT];
        r_invert <= r_req_wdata[CTRL_INVERT_BIT];
      end
      if (w_wr_mask)  r_mask  <= r_req_wdata[NCH-1:0];
      if (w_wr_presc) r_presc <= r_req_wdata[PRESC_W-1:0];
    end
  end

  assign w_tick = r_enable && (r_presc_cnt == r_presc);
  assign w_wrap = w_tick && (r_phase == '1);
  assign w_load = w_wrap | ~r_enable;

  always_ff @(posedge i_clk) begin
    if (i_rst || !r_enable || w_wr_presc || w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
    end
  end

  // A wrap in the same cycle as a STATUS read completion keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase     <= '0;
      r_wrap_flag <= 1'b0;
    end else begin
      if (!r_enable)   r_phase <= '0;
      else if (w_tick) r_phase <= r_phase + DUTY_W'(1);
      if (w_wrap)           r_wrap_flag <= 1'b1;
      else if (w_status_rd) r_wrap_flag <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel #(.DUTY_W(DUTY_W)) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_en   (w_duty_wr[g]),
      .i_wdata   (r_req_wdata[DUTY_W-1:0]),
      .i_phase   (r_phase),
      .i_load    (w_load),
      .i_enable  (r_enable),
      .i_mask    (r_mask[g]),
      .i_invert  (r_invert),
      .o_pending (w_pending[g]),
      .o_led     (o_led[g])
    );
  end

  assign o_bus_ready = r_bus_ready;
  assign o_bus_rdata = r_bus_rdata;

endmodule
